// File: rtl/svfloat_pkg.sv
// rtl/svfloat_pkg.sv - shared types and constants for the float-to-integer converter
package svfloat_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        CLS_NAN  = 3'd0,
        CLS_INF  = 3'd1,
        CLS_ZERO = 3'd2,
        CLS_SUB  = 3'd3,
        CLS_NORM = 3'd4
    } cls_t;

    localparam logic RM_RNE = 1'b0;
    localparam logic RM_RTZ = 1'b1;

endpackage

// File: rtl/svfloat_f2i_if.sv
// rtl/svfloat_f2i_if.sv - operand/result handshake bundle for svfloat_f2i
interface svfloat_f2i_if #(
    parameter int exp_w = 8,
    parameter int man_w = 23,
    parameter int int_w = 32
);
    logic                   in_valid;
    logic                   in_ready;
    logic [exp_w+man_w:0]   in_data;
    logic                   in_signed;
    logic                   in_rm;
    logic                   out_valid;
    logic                   out_ready;
    logic [int_w-1:0]       out_data;
    logic                   out_invalid;
    logic                   out_inexact;

    modport master (
        output in_valid, in_data, in_signed, in_rm, out_ready,
        input  in_ready, out_valid, out_data, out_invalid, out_inexact
    );

    modport slave (
        input  in_valid, in_data, in_signed, in_rm, out_ready,
        output in_ready, out_valid, out_data, out_invalid, out_inexact
    );
endinterface

// File: rtl/svfloat_shr_sticky.sv
// rtl/svfloat_shr_sticky.sv - one power-of-two right-shift stage that folds lost bits into sticky
module svfloat_shr_sticky #(
    parameter int W  = 33,
    parameter int KW = 6
) (
    input  logic [W-1:0]  data_in,
    input  logic          sticky_in,
    input  logic [KW-1:0] stage,
    input  logic          en,
    output logic [W-1:0]  data_out,
    output logic          sticky_out
);
    logic [31:0]  amt;
    logic [W-1:0] lost_mask;
    logic         lost;

    // Shift by 2^stage when enabled; any one bit falling off the bottom sets sticky
    always_comb begin
        amt        = 32'd1 << stage;
        lost_mask  = ~({W{1'b1}} << amt);
        lost       = |(data_in & lost_mask);
        data_out   = en ? (data_in >> amt) : data_in;
        sticky_out = sticky_in | (en & lost);
    end
endmodule

// File: rtl/svfloat_f2i.sv
// rtl/svfloat_f2i.sv - multi-cycle IEEE-style float to integer converter
module svfloat_f2i
    import svfloat_pkg::*;
#(
    parameter int exp_w = 8,
    parameter int man_w = 23,
    parameter int int_w = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    svfloat_f2i_if.slave  bus
);
    localparam int S     = $clog2(int_w + 2);
    localparam int W     = int_w + 1;              // integer bits plus one guard bit
    localparam int FW    = exp_w + man_w + 1;
    localparam int XW    = man_w + 1 + W;
    localparam int BIAS  = (1 << (exp_w - 1)) - 1;
    localparam int TOP_E = int_w - 1 + BIAS;       // exponent placing the hidden bit at the integer MSB

    localparam logic [int_w-1:0] SMAX = {1'b0, {(int_w-1){1'b1}}};
    localparam logic [int_w-1:0] SMIN = {1'b1, {(int_w-1){1'b0}}};
    localparam logic [int_w-1:0] UMAX = {int_w{1'b1}};

    state_t           state;
    logic             sign_q;
    logic             signed_q;
    logic             rm_q;
    cls_t             cls_q;
    logic             big_q;
    logic [S-1:0]     dist_q;
    logic [S-1:0]     cnt_q;
    logic [W-1:0]     work_q;
    logic             sticky_q;
    logic             out_valid_q;
    logic [int_w-1:0] out_data_q;
    logic             out_invalid_q;
    logic             out_inexact_q;

    // Operand decode
    logic             in_sign;
    logic [exp_w-1:0] exp_in;
    logic [man_w-1:0] man_in;
    logic [man_w:0]   sig_in;
    logic [XW-1:0]    ext_in;
    logic [W-1:0]     work_in;
    logic             sticky_in;
    cls_t             cls_in;
    logic             big_in;
    logic [S-1:0]     dist_in;
    int               e_i;

    // Classify the incoming operand and derive its clamped right-shift distance
    always_comb begin
        in_sign   = bus.in_data[FW-1];
        exp_in    = bus.in_data[FW-2 -: exp_w];
        man_in    = bus.in_data[man_w-1:0];
        sig_in    = {exp_in != '0, man_in};
        ext_in    = {sig_in, {W{1'b0}}};
        work_in   = ext_in[XW-1 -: W];
        sticky_in = |ext_in[XW-W-1:0];
        e_i       = 32'(exp_in);
        big_in    = 1'b0;
        dist_in   = '0;
        if (e_i > TOP_E) begin
            big_in = 1'b1;
        end else if (TOP_E - e_i > int_w + 1) begin
            dist_in = S'(int_w + 1);
        end else begin
            dist_in = S'(TOP_E - e_i);
        end
        if (&exp_in) begin
            cls_in = (|man_in) ? CLS_NAN : CLS_INF;
        end else if (exp_in == '0) begin
            cls_in = (|man_in) ? CLS_SUB : CLS_ZERO;
        end else begin
            cls_in = CLS_NORM;
        end
    end

    logic [W-1:0] shr_data;
    logic         shr_sticky;

    svfloat_shr_sticky #(
        .W  (W),
        .KW (S)
    ) u_shr (
        .data_in    (work_q),
        .sticky_in  (sticky_q),
        .stage      (cnt_q),
        .en         (dist_q[cnt_q]),
        .data_out   (shr_data),
        .sticky_out (shr_sticky)
    );

    // Rounding, sign application and range check on the fully shifted value
    logic             guard;
    logic             inc;
    logic [int_w:0]   mag;
    logic             raw_inexact;
    logic             ovf;
    logic             neg_unsigned;
    logic [int_w-1:0] range_min;
    logic [int_w-1:0] range_max;
    logic [int_w-1:0] res_data;
    logic             res_invalid;
    logic             res_inexact;

    always_comb begin
        guard        = work_q[0];
        inc          = (rm_q == RM_RNE) & guard & (sticky_q | work_q[1]);
        mag          = {1'b0, work_q[W-1:1]} + {{int_w{1'b0}}, inc};
        raw_inexact  = guard | sticky_q;
        range_min    = signed_q ? SMIN : '0;
        range_max    = signed_q ? SMAX : UMAX;
        if (signed_q) begin
            ovf = sign_q ? (mag[int_w] | (mag[int_w-1] & (|mag[int_w-2:0])))
                         : (mag[int_w] | mag[int_w-1]);
        end else begin
            ovf = ~sign_q & mag[int_w];
        end
        neg_unsigned = ~signed_q & sign_q & (mag != '0);
        res_data     = sign_q ? (-mag[int_w-1:0]) : mag[int_w-1:0];
        res_invalid  = 1'b0;
        res_inexact  = raw_inexact;
        if (cls_q == CLS_NAN) begin
            res_data    = range_max;
            res_invalid = 1'b1;
            res_inexact = 1'b0;
        end else if (cls_q == CLS_INF || big_q || ovf) begin
            res_data    = sign_q ? range_min : range_max;
            res_invalid = 1'b1;
            res_inexact = 1'b0;
        end else if (neg_unsigned) begin
            res_data    = '0;
            res_invalid = 1'b1;
            res_inexact = 1'b0;
        end
    end

    // Control FSM: accept, shift one stage per cycle, round, then hold the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            sign_q        <= 1'b0;
            signed_q      <= 1'b0;
            rm_q          <= RM_RNE;
            cls_q         <= CLS_ZERO;
            big_q         <= 1'b0;
            dist_q        <= '0;
            cnt_q         <= '0;
            work_q        <= '0;
            sticky_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_invalid_q <= 1'b0;
            out_inexact_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q   <= in_sign;
                        signed_q <= bus.in_signed;
                        rm_q     <= bus.in_rm;
                        cls_q    <= cls_in;
                        big_q    <= big_in;
                        dist_q   <= dist_in;
                        work_q   <= work_in;
                        sticky_q <= sticky_in;
                        cnt_q    <= S'(S - 1);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    work_q   <= shr_data;
                    sticky_q <= shr_sticky;
                    if (cnt_q == '0) begin
                        state <= ROUND;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ROUND: begin
                    out_data_q    <= res_data;
                    out_invalid_q <= res_invalid;
                    out_inexact_q <= res_inexact;
                    out_valid_q   <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_invalid = out_invalid_q;
    assign bus.out_inexact = out_inexact_q;

endmodule

// File: tb/tb_svfloat_f2i.sv
// tb/tb_svfloat_f2i.sv - directed table-driven bench for svfloat_f2i
module tb_svfloat_f2i;

    localparam int LAT_TOTAL = 8;   // edges counted from and including the accepting edge
    localparam int BOUND     = 20;

    typedef struct {
        logic [31:0] data;
        logic        sgn;
        logic        rm;
        logic [31:0] exp_d;
        logic        exp_inv;
        logic        exp_inx;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    svfloat_f2i_if bus ();

    svfloat_f2i dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] d, input logic s, input logic r);
        bus.in_data   = d;
        bus.in_signed = s;
        bus.in_rm     = r;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < BOUND) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int          lat;
        bit          seen;
        logic [31:0] held;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_signed = 1'b0;
        bus.in_rm     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out_data", bus.out_data, 32'd0);
        chk("reset out_invalid", 32'(bus.out_invalid), 32'd0);
        chk("reset out_inexact", 32'(bus.out_inexact), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //            data         sgn   rm    expected      inv   inx
        vecs.push_back('{32'h40200000, 1'b1, 1'b0, 32'h00000002, 1'b0, 1'b1}); // 2.5 RNE
        vecs.push_back('{32'h40200000, 1'b1, 1'b1, 32'h00000002, 1'b0, 1'b1}); // 2.5 RTZ
        vecs.push_back('{32'h40600000, 1'b1, 1'b0, 32'h00000004, 1'b0, 1'b1}); // 3.5 RNE
        vecs.push_back('{32'h40600000, 1'b1, 1'b1, 32'h00000003, 1'b0, 1'b1}); // 3.5 RTZ
        vecs.push_back('{32'h3F800000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0}); // 1.0
        vecs.push_back('{32'hCF000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b0}); // -2^31
        vecs.push_back('{32'h4F000000, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0}); // 2^31 signed
        vecs.push_back('{32'h7FC00000, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b0}); // NaN signed
        vecs.push_back('{32'h7FC00000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0}); // NaN unsigned
        vecs.push_back('{32'hBF800000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0}); // -1.0 unsigned
        vecs.push_back('{32'h80000000, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b0}); // -0
        vecs.push_back('{32'h00000001, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1}); // subnormal
        vecs.push_back('{32'hBF000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b1}); // -0.5 unsigned
        vecs.push_back('{32'hBF400000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0}); // -0.75 unsigned RNE
        vecs.push_back('{32'hBF400000, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1}); // -0.75 unsigned RTZ
        vecs.push_back('{32'hFF800000, 1'b1, 1'b0, 32'h80000000, 1'b1, 1'b0}); // -inf signed
        vecs.push_back('{32'h7F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0}); // +inf unsigned
        vecs.push_back('{32'h4F800000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0}); // 2^32 unsigned
        vecs.push_back('{32'h4F7FFFFF, 1'b0, 1'b0, 32'hFFFFFF00, 1'b0, 1'b0}); // just below 2^32
        vecs.push_back('{32'h4EFFFFFF, 1'b1, 1'b0, 32'h7FFFFF80, 1'b0, 1'b0}); // just below 2^31
        vecs.push_back('{32'hC0200000, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1}); // -2.5 RNE
        vecs.push_back('{32'h3EFFFFFF, 1'b1, 1'b0, 32'h00000000, 1'b0, 1'b1}); // just under 0.5
        vecs.push_back('{32'h3FC00000, 1'b1, 1'b0, 32'h00000002, 1'b0, 1'b1}); // 1.5 RNE
        vecs.push_back('{32'h4B000001, 1'b1, 1'b0, 32'h00800001, 1'b0, 1'b0}); // 2^23+1 exact

        foreach (vecs[i]) begin
            chk($sformatf("v%0d in_ready before", i), 32'(bus.in_ready), 32'd1);
            start_op(vecs[i].data, vecs[i].sgn, vecs[i].rm);
            wait_result(lat);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(LAT_TOTAL));
            chk($sformatf("v%0d in_ready in DONE", i), 32'(bus.in_ready), 32'd0);
            chk($sformatf("v%0d data %h", i, vecs[i].data), bus.out_data, vecs[i].exp_d);
            chk($sformatf("v%0d invalid %h", i, vecs[i].data), 32'(bus.out_invalid), 32'(vecs[i].exp_inv));
            chk($sformatf("v%0d inexact %h", i, vecs[i].data), 32'(bus.out_inexact), 32'(vecs[i].exp_inx));
            consume();
            chk($sformatf("v%0d out_valid after consume", i), 32'(bus.out_valid), 32'd0);
        end

        // Backpressure: result must hold while out_ready stays low
        start_op(32'h40600000, 1'b1, 1'b0);
        wait_result(lat);
        chk("bp latency", 32'(lat), 32'(LAT_TOTAL));
        held = bus.out_data;
        chk("bp data", held, 32'h00000004);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp c%0d out_valid", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp c%0d out_data", c), bus.out_data, 32'h00000004);
            chk($sformatf("bp c%0d in_ready", c), 32'(bus.in_ready), 32'd0);
        end
        consume();
        chk("bp idle in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp idle out_valid", 32'(bus.out_valid), 32'd0);

        // Reset arriving on the third SHIFT cycle discards the operation
        start_op(32'h3F800000, 1'b1, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst mid in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst mid out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst mid out_data", bus.out_data, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        chk("rst mid no result", 32'(seen), 32'd0);

        // Normal operation resumes after the aborted conversion
        start_op(32'h40200000, 1'b1, 1'b0);
        wait_result(lat);
        chk("post-rst latency", 32'(lat), 32'(LAT_TOTAL));
        chk("post-rst data", bus.out_data, 32'h00000002);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
